// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported 2k x 16 SRAM between the CPU execute stage and a host/debug loader.
// The CPU has priority. A loader request that has waited MAX_WAIT eligible cycles is forced into a slot,
// which stalls the CPU for that one cycle. SRAM read data arrives one cycle after the address.
// Ports:
//   clk, reset (asynchronous, active-low)
//   cpuReq/cpuWrite/cpuAdrx/cpuDataIn  -> CPU access request; cpuStall: access not performed; cpuDataOut: SRAM read data
//   ldReq/ldWrite/ldAdrx/ldDataIn      -> loader request, held until ldAck
//   ldAck/ldDataOut                    -> one-cycle completion pulse with the loader read data
//   memAdrx/memWrite/memDataIn/memDataOut -> SRAM port
//   stallCnt                           -> CPU stall-cycle count (built only with DMEM_ARB_PERF_EN defined, else 0)
module dmem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              cpuWrite,
    input  logic [ADDR_W-1:0] cpuAdrx,
    input  logic [DATA_W-1:0] cpuDataIn,
    output logic              cpuStall,
    output logic [DATA_W-1:0] cpuDataOut,
    input  logic              ldReq,
    input  logic              ldWrite,
    input  logic [ADDR_W-1:0] ldAdrx,
    input  logic [DATA_W-1:0] ldDataIn,
    output logic              ldAck,
    output logic [DATA_W-1:0] ldDataOut,
    output logic [ADDR_W-1:0] memAdrx,
    output logic              memWrite,
    output logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] memDataOut,
    output logic [15:0]       stallCnt
);
    logic              ack_pending;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] ld_hold;
    logic              eligible;
    logic              force_ld;
    logic              grant_ld;
    logic              grant_cpu;

    // Grants are gated by reset so the SRAM port and stall go quiet the instant reset asserts.
    always_comb begin
        eligible  = reset & ldReq & ~ack_pending;
        force_ld  = eligible & (wait_cnt >= 8'(MAX_WAIT));
        grant_ld  = eligible & (force_ld | ~cpuReq);
        grant_cpu = reset & cpuReq & ~grant_ld;
    end

    assign memAdrx    = grant_ld ? ldAdrx : cpuAdrx;
    assign memWrite   = grant_ld ? ldWrite : (cpuWrite & grant_cpu);
    assign memDataIn  = grant_ld ? ldDataIn : cpuDataIn;
    assign cpuStall   = cpuReq & grant_ld;
    assign cpuDataOut = memDataOut;
    assign ldAck      = ack_pending;
    // Live SRAM data during the ack cycle; the captured copy keeps the output stable afterwards.
    assign ldDataOut  = ack_pending ? memDataOut : ld_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_pending <= 1'b0;
            wait_cnt    <= '0;
            ld_hold     <= '0;
        end else begin
            ack_pending <= grant_ld;
            if (grant_ld)
                wait_cnt <= '0;
            else if (eligible && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
            if (ack_pending)
                ld_hold <= memDataOut;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (cpuStall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
    assign stallCnt = stall_cnt;
`else
    assign stallCnt = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural SRAM and a reference model.
module tb_dmem_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int MW = 8;
`ifdef DMEM_ARB_PERF_EN
    localparam logic [15:0] EXP_STALLS = 16'd3;
`else
    localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpuReq, cpuWrite, ldReq, ldWrite;
    logic [AW-1:0] cpuAdrx, ldAdrx, memAdrx;
    logic [DW-1:0] cpuDataIn, ldDataIn, memDataIn, memDataOut, cpuDataOut, ldDataOut;
    logic          cpuStall, ldAck, memWrite;
    logic [15:0]   stallCnt;
    logic [DW-1:0] sram [0:2047];
    int            checks = 0;
    int            failures = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAdrx(cpuAdrx), .cpuDataIn(cpuDataIn),
        .cpuStall(cpuStall), .cpuDataOut(cpuDataOut),
        .ldReq(ldReq), .ldWrite(ldWrite), .ldAdrx(ldAdrx), .ldDataIn(ldDataIn),
        .ldAck(ldAck), .ldDataOut(ldDataOut),
        .memAdrx(memAdrx), .memWrite(memWrite), .memDataIn(memDataIn), .memDataOut(memDataOut),
        .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWrite) sram[memAdrx] <= memDataIn;
        memDataOut <= sram[memAdrx];
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpuReq = 0; cpuWrite = 0; cpuAdrx = '0; cpuDataIn = '0;
        ldReq = 0; ldWrite = 0; ldAdrx = '0; ldDataIn = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        reset = 0;
        cpuReq = 1; cpuWrite = 1; cpuAdrx = 11'h001; cpuDataIn = 16'h5555;
        ldReq = 1; ldWrite = 1; ldAdrx = 11'h002; ldDataIn = 16'hAAAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ldAck !== 1'b0) begin failures++; $display("FAIL reset_ldAck got=%b exp=0", ldAck); end
        checks++; if (memWrite !== 1'b0) begin failures++; $display("FAIL reset_memWrite got=%b exp=0", memWrite); end
        checks++; if (cpuStall !== 1'b0) begin failures++; $display("FAIL reset_cpuStall got=%b exp=0", cpuStall); end
        checks++; if (stallCnt !== 16'd0) begin failures++; $display("FAIL reset_stallCnt got=%h exp=0", stallCnt); end
        idle_inputs();
        reset = 1;
        tick();
    endtask

    task automatic test_random();
        bit            m_pending = 0, exp_ld_read = 0, prev_cpu_read = 0, prev_stall = 0, g, gc;
        int            m_wait = 0, req_start = 0;
        logic [DW-1:0] exp_mem [0:2047];
        logic [DW-1:0] exp_ld_data = '0, exp_cpu_data = '0;
        logic          exp_wr;
        for (int i = 0; i < 2048; i++) exp_mem[i] = '0;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            cpuReq = ($urandom_range(0, 9) < 8);
            cpuWrite = 1'($urandom);
            cpuAdrx = 11'($urandom_range(0, 15));
            cpuDataIn = 16'($urandom);
            if (m_pending || !ldReq) begin
                ldReq = m_pending ? 1'($urandom) : ($urandom_range(0, 3) == 0);
                if (ldReq) begin
                    ldWrite = 1'($urandom);
                    ldAdrx = 11'($urandom_range(0, 15));
                    ldDataIn = 16'($urandom);
                    req_start = m_pending ? cyc + 1 : cyc;
                end
            end
            @(negedge clk);
            g = ldReq && !m_pending && (m_wait >= MW || !cpuReq);
            gc = cpuReq && !g;
            exp_wr = g ? ldWrite : (gc && cpuWrite);
            checks++; if (cpuStall !== (cpuReq && g)) begin failures++; $display("FAIL rnd_cpuStall cyc=%0d got=%b exp=%b", cyc, cpuStall, cpuReq && g); end
            checks++; if (ldAck !== m_pending) begin failures++; $display("FAIL rnd_ldAck cyc=%0d got=%b exp=%b", cyc, ldAck, m_pending); end
            checks++; if (memWrite !== exp_wr) begin failures++; $display("FAIL rnd_memWrite cyc=%0d got=%b exp=%b", cyc, memWrite, exp_wr); end
            if (g || gc) begin
                checks++; if (memAdrx !== (g ? ldAdrx : cpuAdrx)) begin failures++; $display("FAIL rnd_memAdrx cyc=%0d got=%h exp=%h", cyc, memAdrx, g ? ldAdrx : cpuAdrx); end
            end
            if (exp_wr) begin
                checks++; if (memDataIn !== (g ? ldDataIn : cpuDataIn)) begin failures++; $display("FAIL rnd_memDataIn cyc=%0d got=%h exp=%h", cyc, memDataIn, g ? ldDataIn : cpuDataIn); end
            end
            if (m_pending && exp_ld_read) begin
                checks++; if (ldDataOut !== exp_ld_data) begin failures++; $display("FAIL rnd_ldDataOut cyc=%0d got=%h exp=%h", cyc, ldDataOut, exp_ld_data); end
            end
            if (m_pending) begin
                checks++; if (cyc - req_start > MW + 1) begin failures++; $display("FAIL rnd_ld_latency cyc=%0d got=%0d exp<=%0d", cyc, cyc - req_start, MW + 1); end
            end
            if (prev_cpu_read) begin
                checks++; if (cpuDataOut !== exp_cpu_data) begin failures++; $display("FAIL rnd_cpuDataOut cyc=%0d got=%h exp=%h", cyc, cpuDataOut, exp_cpu_data); end
            end
            if (prev_stall) begin
                checks++; if (cpuStall !== 1'b0) begin failures++; $display("FAIL rnd_double_stall cyc=%0d got=%b exp=0", cyc, cpuStall); end
            end
            @(posedge clk);
            prev_stall = cpuReq && g;
            prev_cpu_read = gc && !cpuWrite;
            if (prev_cpu_read) exp_cpu_data = exp_mem[cpuAdrx];
            if (g) begin
                exp_ld_read = !ldWrite;
                exp_ld_data = exp_mem[ldAdrx];
                if (ldWrite) exp_mem[ldAdrx] = ldDataIn;
                m_wait = 0;
                m_pending = 1;
            end else begin
                if (ldReq && !m_pending) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
                if (gc && cpuWrite) exp_mem[cpuAdrx] = cpuDataIn;
                m_pending = 0;
            end
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_loader_rw();
        do_reset();
        ldReq = 1; ldWrite = 1; ldAdrx = 11'h005; ldDataIn = 16'hBEEF;
        @(negedge clk);
        checks++; if (memWrite !== 1'b1 || memAdrx !== 11'h005) begin failures++; $display("FAIL ldw_grant got=%b/%h exp=1/005", memWrite, memAdrx); end
        checks++; if (cpuStall !== 1'b0) begin failures++; $display("FAIL ldw_stall got=%b exp=0", cpuStall); end
        tick();
        ldReq = 0;
        @(negedge clk);
        checks++; if (ldAck !== 1'b1) begin failures++; $display("FAIL ldw_ack got=%b exp=1", ldAck); end
        tick();
        ldReq = 1; ldWrite = 0;
        @(negedge clk);
        checks++; if (memWrite !== 1'b0 || ldAck !== 1'b0) begin failures++; $display("FAIL ldr_grant got=%b/%b exp=0/0", memWrite, ldAck); end
        tick();
        ldReq = 0;
        @(negedge clk);
        checks++; if (ldAck !== 1'b1 || ldDataOut !== 16'hBEEF) begin failures++; $display("FAIL ldr_data got=%b/%h exp=1/beef", ldAck, ldDataOut); end
        checks++; if (cpuStall !== 1'b0) begin failures++; $display("FAIL ldr_stall got=%b exp=0", cpuStall); end
        tick();
    endtask

    task automatic test_forced_slot();
        do_reset();
        cpuReq = 1; cpuWrite = 0; ldReq = 1; ldWrite = 0; ldAdrx = 11'h400;
        for (int c = 0; c < 10; c++) begin
            cpuAdrx = 11'(c + 1);
            if (c == 9) ldReq = 0;
            @(negedge clk);
            if (c < 8) begin
                checks++; if (memAdrx !== cpuAdrx || cpuStall !== 1'b0) begin failures++; $display("FAIL force_cpu c=%0d got=%h/%b exp=%h/0", c, memAdrx, cpuStall, cpuAdrx); end
            end else if (c == 8) begin
                checks++; if (memAdrx !== 11'h400 || cpuStall !== 1'b1) begin failures++; $display("FAIL force_slot got=%h/%b exp=400/1", memAdrx, cpuStall); end
            end else begin
                checks++; if (ldAck !== 1'b1 || cpuStall !== 1'b0 || memAdrx !== cpuAdrx) begin failures++; $display("FAIL force_ack got=%b/%b/%h exp=1/0/%h", ldAck, cpuStall, memAdrx, cpuAdrx); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        do_reset();
        cpuReq = 1; cpuWrite = 1; cpuAdrx = 11'h010; cpuDataIn = 16'h1234;
        ldReq = 1; ldWrite = 0; ldAdrx = 11'h010;
        @(negedge clk);
        checks++; if (cpuStall !== 1'b0 || memWrite !== 1'b1 || memDataIn !== 16'h1234) begin failures++; $display("FAIL coll_cpu got=%b/%b/%h exp=0/1/1234", cpuStall, memWrite, memDataIn); end
        tick();
        cpuReq = 0;
        @(negedge clk);
        checks++; if (memWrite !== 1'b0 || memAdrx !== 11'h010) begin failures++; $display("FAIL coll_ld_grant got=%b/%h exp=0/010", memWrite, memAdrx); end
        tick();
        ldReq = 0;
        @(negedge clk);
        checks++; if (ldAck !== 1'b1 || ldDataOut !== 16'h1234) begin failures++; $display("FAIL coll_ld_data got=%b/%h exp=1/1234", ldAck, ldDataOut); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit exp_g, exp_a;
        do_reset();
        cpuAdrx = 11'h7FF; ldReq = 1; ldWrite = 1; ldAdrx = 11'h020; ldDataIn = 16'($urandom);
        for (int c = 0; c < 4; c++) begin
            exp_g = (c % 2 == 0);
            exp_a = (c % 2 == 1);
            @(negedge clk);
            checks++; if (memWrite !== exp_g || ldAck !== exp_a || memAdrx !== (exp_g ? 11'h020 : 11'h7FF)) begin failures++; $display("FAIL b2b c=%0d got=%b/%b/%h exp=%b/%b", c, memWrite, ldAck, memAdrx, exp_g, exp_a); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int first = -1;
        do_reset();
        cpuReq = 1; ldReq = 1;
        repeat (3) tick();
        ldReq = 0;
        tick();
        cpuReq = 0; ldReq = 1; ldWrite = 0; ldAdrx = 11'h003;
        tick();
        checks++; if (ldAck !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%b exp=1", ldAck); end
        reset = 0; cpuReq = 1; cpuWrite = 1; ldWrite = 1;
        #1;
        checks++; if (ldAck !== 1'b0 || memWrite !== 1'b0 || cpuStall !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b/%b/%b exp=0/0/0", ldAck, memWrite, cpuStall); end
        idle_inputs();
        @(negedge clk);
        reset = 1;
        tick();
        @(negedge clk);
        checks++; if (ldAck !== 1'b0 || stallCnt !== 16'd0) begin failures++; $display("FAIL rmid_after got=%b/%h exp=0/0", ldAck, stallCnt); end
        tick();
        cpuReq = 1; ldReq = 1;
        for (int c = 0; c < MW + 3 && first < 0; c++) begin
            @(negedge clk);
            if (cpuStall) first = c;
            tick();
        end
        checks++; if (first !== MW) begin failures++; $display("FAIL rmid_waitcnt first_stall=%0d exp=%0d", first, MW); end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_count();
        bit exp_s;
        do_reset();
        cpuReq = 1; ldReq = 1;
        for (int c = 0; c < 30; c++) begin
            exp_s = (c == 8 || c == 18 || c == 28);
            @(negedge clk);
            checks++; if (cpuStall !== exp_s) begin failures++; $display("FAIL scnt_stall c=%0d got=%b exp=%b", c, cpuStall, exp_s); end
            tick();
        end
        @(negedge clk);
        checks++; if (stallCnt !== EXP_STALLS) begin failures++; $display("FAIL scnt_value got=%0d exp=%0d", stallCnt, EXP_STALLS); end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) sram[i] = '0;
        memDataOut = '0;
        idle_inputs();
        test_reset();
        test_random();
        test_loader_rw();
        test_forced_slot();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_stall_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the 2k x 16 data memory port. It shares the single-ported synchronous SRAM between the pipelined CPU's execute-stage access and a host/debug loader port. The CPU has priority. A starvation counter forces a loader slot, stalling the CPU for one cycle. Loader accesses use a req/ack handshake that returns read data with a one-cycle memory latency.

## Interface
Parameters:
- ADDR_W, 11, memory address width (2k words)
- DATA_W, 16, memory data width
- MAX_WAIT, 8, loader wait cycles before a forced slot; legal 1..255

Ports:
- clk  in  1  system clock (divided or full-rate CPU clock)
- reset  in  1  asynchronous, active-low reset
- cpuReq  in  1  CPU execute stage requests a memory access this cycle
- cpuWrite  in  1  CPU access is a write (valid with cpuReq)
- cpuAdrx  in  ADDR_W  CPU address
- cpuDataIn  in  DATA_W  CPU write data
- cpuStall  out  1  CPU access not performed this cycle; pipeline must hold
- cpuDataOut  out  DATA_W  read data, equals memDataOut
- ldReq  in  1  loader request; held until ldAck
- ldWrite  in  1  loader access is a write
- ldAdrx  in  ADDR_W  loader address
- ldDataIn  in  DATA_W  loader write data
- ldAck  out  1  one-cycle pulse: loader access completed
- ldDataOut  out  DATA_W  loader read data, valid while ldAck=1
- memAdrx  out  ADDR_W  SRAM address
- memWrite  out  1  SRAM write enable
- memDataIn  out  DATA_W  SRAM write data
- memDataOut  in  DATA_W  SRAM read data, one cycle after address
- stallCnt  out  16  CPU stall-cycle counter (see Configuration)

## Operation
- Registered state: ackPending (1b), waitCnt (8b), ldDataOut capture path.
- The grant decision is combinational each cycle:
  - force = ldReq & ~ackPending & (waitCnt >= MAX_WAIT)
  - grantLd = ldReq & ~ackPending & (force | ~cpuReq)
  - grantCpu = cpuReq & ~grantLd
- Memory port muxing: when grantLd, drive memAdrx/memWrite/memDataIn from the ld* inputs. Otherwise drive them from the cpu* inputs, with memWrite = cpuWrite & grantCpu. When neither is granted, memWrite=0 and memAdrx=cpuAdrx.
- cpuStall = cpuReq & grantLd.
- Loader handshake:
  - Grant in cycle N sets ackPending at the edge ending N.
  - Cycle N+1: ldAck=1 and ldDataOut=memDataOut (read result; don't-care for writes). ackPending clears at the edge ending N+1.
  - ldReq is ignored while ackPending=1, so there are no back-to-back loader grants. The loader drops or re-presents ldReq in N+1, and a re-presented request is eligible from N+2.
- waitCnt:
  - Cleared on grantLd.
  - Incremented, saturating at 255, on cycles with ldReq & ~ackPending & ~grantLd.
  - Held otherwise, including when ldReq drops without a grant.
- cpuDataOut = memDataOut. CPU read latency equals SRAM latency, and the CPU pipeline accounts for it.

## Timing
- Reset (reset=0, async): ackPending=0, waitCnt=0, stallCnt=0. While reset=0: ldAck=0, memWrite=0, cpuStall=0.
- Loader latency:
  - Idle CPU: ldReq asserted in cycle N, ldAck in N+1.
  - CPU saturating the port: ldAck no later than cycle N+MAX_WAIT+1.
- Forced slot: exactly one cpuStall cycle per forced grant. No two consecutive stall cycles are possible.
- Simultaneous cpuReq and ldReq with waitCnt < MAX_WAIT: CPU wins, and waitCnt increments.
- Reset asserted mid-handshake: the pending ldAck is dropped. The loader must re-issue after reset release.

## Configuration
- DMEM_ARB_PERF_EN defined: stallCnt increments on every cycle with cpuStall=1 and saturates at 16'hFFFF.
- Undefined: the counter is not built and stallCnt is tied to 0.

## Test plan
- Idle CPU, loader write adrx 11'h005 data 16'hBEEF, then loader read 11'h005 → write ldAck in N+1; read ldAck with ldDataOut=16'hBEEF; cpuStall never asserted.
- CPU cpuReq=1 every cycle, MAX_WAIT=8, ldReq raised at cycle 0 → memAdrx follows cpuAdrx for cycles 0-7; grantLd and cpuStall=1 at cycle 8; ldAck at cycle 9; waitCnt=0 after.
- Same cycle CPU write 11'h010=16'h1234 and loader read 11'h010, waitCnt=0 → CPU write performed; loader read later returns 16'h1234.
- Loader holds ldReq through ack (ack cycle N+1) → no grant in N+1; next grant no earlier than N+2.
- Assert reset low while ackPending=1 → ldAck stays 0, memWrite=0 immediately (async); after release waitCnt=0, stallCnt=0.
- With DMEM_ARB_PERF_EN, 3 forced slots → stallCnt=3. Without the macro → stallCnt=0.
